// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// State encoding, counter sizing and the divide-by-zero quotient.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] DZ_QUOT = '1;

  function automatic int unsigned cnt_width(
    input int unsigned w
  );
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/addsub_nbit.sv
// N-bit add/subtract stage: a + (b ^ sub) + sub.
// c_out is the true carry, i.e. 1 means a >= b when subtracting.
module addsub_nbit #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] result,
  output logic         c_out
);

  logic [N-1:0] bx;

  assign bx = b ^ {N{sub}};

  assign {c_out, result} = {1'b0, a}
                         + {1'b0, bx}
                         + {{N{1'b0}}, sub};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement truncating division.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r, r_n, t;
  logic [WIDTH-1:0] q, q_n, d;
  logic [2*WIDTH:0] sh;
  logic             c_out;
  logic             accept, zero_div, last;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_fin, r_fin;
`ifdef DIV_SIGNED_EN
  logic             neg_q, neg_r;
`endif

  assign accept   = start && (state != CALC);
  assign zero_div = (divisor == '0);
  assign last     = (state == CALC) &&
                    (cnt == CW'(WIDTH - 1));

  always_comb begin
    sh  = {r, q} << 1;
    r_n = c_out ? t : sh[2*WIDTH:WIDTH];
    q_n = sh[WIDTH-1:0] |
          {{(WIDTH-1){1'b0}}, c_out};
  end

  addsub_nbit #(
    .N(WIDTH + 1)
  ) u_addsub (
    .a      (sh[2*WIDTH:WIDTH]),
    .b      ({1'b0, d}),
    .sub    (1'b1),
    .result (t),
    .c_out  (c_out)
  );

  // Core always runs on magnitudes; signs are restored on exit
`ifdef DIV_SIGNED_EN
  always_comb begin
    a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    q_fin = neg_q ? -q_n : q_n;
    r_fin = neg_r ? -r_n[WIDTH-1:0]
                  : r_n[WIDTH-1:0];
  end
`else
  always_comb begin
    a_mag = dividend;
    b_mag = divisor;
    q_fin = q_n;
    r_fin = r_n[WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_n = zero_div ? DONE : CALC;
        else       state_n = IDLE;
      end
      CALC: begin
        if (last) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else if (accept) begin
      if (zero_div) begin
        quotient    <= DZ_QUOT[WIDTH-1:0];
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        r   <= '0;
        q   <= a_mag;
        d   <= b_mag;
        cnt <= '0;
`ifdef DIV_SIGNED_EN
        neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        neg_r <= dividend[WIDTH-1];
`endif
      end
    end else if (state == CALC) begin
      r   <= r_n;
      q   <= q_n;
      cnt <= cnt + CW'(1);
      if (last) begin
        quotient    <= q_fin;
        remainder   <= r_fin;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider with a cycle-level reference model.
// Compile with DIV_SIGNED_EN to exercise the signed build.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int nvec  = 0;
  int nfail = 0;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Result packed as {dz, quotient, remainder}
  function automatic logic [2*W:0] ref_div(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
`ifdef DIV_SIGNED_EN
    int sa, sb, qi, ri;
`endif
    if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef DIV_SIGNED_EN
    sa = $signed(a);
    sb = $signed(b);
    qi = sa / sb;
    ri = sa % sb;
    return {1'b0, W'(qi), W'(ri)};
`else
    return {1'b0, a / b, a % b};
`endif
  endfunction

  // Model: cycles-to-done countdown plus pending result
  bit           m_act  = 0;
  int           m_wait = 0;
  logic [2*W:0] m_pend = '0;
  logic [2*W:0] m_res  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act  <= 0;
      m_wait <= 0;
      m_res  <= '0;
    end else if (start && !(m_act && m_wait != 0)) begin
      m_act  <= 1;
      m_pend <= ref_div(dividend, divisor);
      if (divisor == '0) begin
        m_wait <= 0;
        m_res  <= ref_div(dividend, divisor);
      end else begin
        m_wait <= W;
      end
    end else if (m_act) begin
      if (m_wait == 0) begin
        m_act <= 0;
      end else begin
        m_wait <= m_wait - 1;
        if (m_wait == 1) m_res <= m_pend;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_act && m_wait != 0);
    chk("done", done, m_act && m_wait == 0);
    chk("quotient", quotient, m_res[2*W-1:W]);
    chk("remainder", remainder, m_res[W-1:0]);
    chk("div_by_zero", div_by_zero, m_res[2*W]);
  end

  task automatic issue(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic wait_done(
    output int n,
    output int nb
  );
    n  = 0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (done) return;
      if (busy) nb++;
    end
    nvec++;
    nfail++;
    $display("FAIL wait_done: got no done expected done within 40");
  endtask

  task automatic res(
    input string        tag,
    input logic [W-1:0] eq,
    input logic [W-1:0] er,
    input logic         edz
  );
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dz"}, div_by_zero, edz);
  endtask

  int n, nb;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    res("rst", 0, 0, 0);

`ifndef DIV_SIGNED_EN
    issue(13, 3);
    wait_done(n, nb);
    chk("lat_13_3", n, 5);
    chk("busy_cycles", nb, 4);
    res("d13_3", 4, 1, 0);

    issue(15, 1);
    wait_done(n, nb);
    res("d15_1", 15, 0, 0);
    issue(5, 7);
    wait_done(n, nb);
    chk("lat_b2b", n, 5);
    res("d5_7", 0, 5, 0);

    issue(9, 0);
    wait_done(n, nb);
    chk("lat_dz", n, 1);
    res("d9_0", 15, 9, 1);
    issue(6, 2);
    wait_done(n, nb);
    res("d6_2", 3, 0, 0);

    issue(12, 5);
    repeat (2) @(posedge clk);
    #2 dividend = 1;
    divisor = 1;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done(n, nb);
    res("d12_5", 2, 2, 0);
    repeat (3) begin
      @(negedge clk);
      chk("single_done", done, 0);
    end

    issue(14, 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    res("abort", 0, 0, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_done", done, 0);
    end
    issue(14, 3);
    wait_done(n, nb);
    res("d14_3", 4, 2, 0);

    issue(0, 5);
    wait_done(n, nb);
    res("d0_5", 0, 0, 0);
    issue(15, 15);
    wait_done(n, nb);
    res("d15_15", 1, 0, 0);
`else
    issue(4'h7, 4'hE);
    wait_done(n, nb);
    chk("lat_s", n, 5);
    res("s7_m2", 4'hD, 4'h1, 0);
    issue(4'h8, 4'hF);
    wait_done(n, nb);
    res("sm8_m1", 4'h8, 4'h0, 0);
    issue(4'h9, 4'h2);
    wait_done(n, nb);
    res("sm7_2", 4'hD, 4'hF, 0);
    issue(4'h5, 4'h0);
    wait_done(n, nb);
    chk("lat_sdz", n, 1);
    res("s5_0", 4'hF, 4'h5, 1);
    issue(4'hA, 4'h3);
    wait_done(n, nb);
    res("sm6_3", 4'hE, 4'h0, 0);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
